// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register for the five-stage MIPS core.
// Holds the PC, addresses instruction memory, and resolves next-PC from ID's redirect select.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [1:0]  NpcSel,
  input  logic [31:0] JrTarget,
  input  logic [31:0] ImInstr,
  output logic [9:0]  ImAddr,
  output logic [31:0] F_PC,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic [31:0] D_PC8,
  output logic        AddrErr
);

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [31:0] PC_HI = RESET_PC + 32'h0000_0FFC;

  logic [31:0] next_pc;
  logic [31:0] branch_offset;

  assign branch_offset = {{14{D_Instr[15]}}, D_Instr[15:0], 2'b00};

  // Redirect targets are formed from the instruction currently in ID, not from F_PC.
  always_comb begin
    next_pc = F_PC + 32'd4;
    unique case (NpcSel)
      NPC_SEQ:    next_pc = F_PC + 32'd4;
      NPC_BRANCH: next_pc = D_PC + 32'd4 + branch_offset;
      NPC_JUMP:   next_pc = {D_PC[31:28], D_Instr[25:0], 2'b00};
      NPC_JR:     next_pc = JrTarget;
      default:    next_pc = F_PC + 32'd4;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      F_PC    <= RESET_PC;
      D_Instr <= NOP_INSTR;
      D_PC    <= RESET_PC;
      D_PC8   <= RESET_PC + 32'd8;
    end else if (!Stall) begin
      F_PC    <= next_pc;
      D_Instr <= Flush ? NOP_INSTR : ImInstr;
      D_PC    <= F_PC;
      D_PC8   <= F_PC + 32'd8;
    end
  end

  // Out-of-window or misaligned PCs are only flagged; the truncated address is still driven.
  assign ImAddr  = F_PC[11:2];
  assign AddrErr = (F_PC < RESET_PC) || (F_PC > PC_HI) || (F_PC[1:0] != 2'b00);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: sequential fetch, branch/jal/jr redirects,
// stall, flush, address-error flag and reset priority.
module tb_fetch_stage;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        Flush;
  logic [1:0]  NpcSel;
  logic [31:0] JrTarget;
  logic [31:0] ImInstr;
  logic [9:0]  ImAddr;
  logic [31:0] F_PC;
  logic [31:0] D_Instr;
  logic [31:0] D_PC;
  logic [31:0] D_PC8;
  logic        AddrErr;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];

  fetch_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .NpcSel(NpcSel),
    .JrTarget(JrTarget), .ImInstr(ImInstr), .ImAddr(ImAddr), .F_PC(F_PC),
    .D_Instr(D_Instr), .D_PC(D_PC), .D_PC8(D_PC8), .AddrErr(AddrErr)
  );

  assign ImInstr = mem[ImAddr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not end");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; NpcSel = 2'b00; JrTarget = 32'h0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (F_PC !== 32'h3000) begin errors++; $display("[TB] FAIL reset_fpc got %h want %h", F_PC, 32'h3000); end
    checks++; if (D_Instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_dinstr got %h want %h", D_Instr, 32'h0); end
    checks++; if (D_PC !== 32'h3000) begin errors++; $display("[TB] FAIL reset_dpc got %h want %h", D_PC, 32'h3000); end
    checks++; if (D_PC8 !== 32'h3008) begin errors++; $display("[TB] FAIL reset_dpc8 got %h want %h", D_PC8, 32'h3008); end
    checks++; if (ImAddr !== 10'h000) begin errors++; $display("[TB] FAIL reset_imaddr got %h want %h", ImAddr, 10'h000); end
    checks++; if (AddrErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_addrerr got %b want 0", AddrErr); end
  endtask

  task automatic test_sequential();
    NpcSel = 2'b00;
    tick();
    checks++; if (F_PC !== 32'h3004) begin errors++; $display("[TB] FAIL seq1_fpc got %h want %h", F_PC, 32'h3004); end
    checks++; if (D_Instr !== 32'h24010001) begin errors++; $display("[TB] FAIL seq1_dinstr got %h want %h", D_Instr, 32'h24010001); end
    checks++; if (D_PC8 !== 32'h3008) begin errors++; $display("[TB] FAIL seq1_dpc8 got %h want %h", D_PC8, 32'h3008); end
    tick();
    checks++; if (F_PC !== 32'h3008) begin errors++; $display("[TB] FAIL seq2_fpc got %h want %h", F_PC, 32'h3008); end
    checks++; if (D_Instr !== 32'h24020002) begin errors++; $display("[TB] FAIL seq2_dinstr got %h want %h", D_Instr, 32'h24020002); end
    checks++; if (D_PC !== 32'h3004) begin errors++; $display("[TB] FAIL seq2_dpc got %h want %h", D_PC, 32'h3004); end
    checks++; if (D_PC8 !== 32'h300C) begin errors++; $display("[TB] FAIL seq2_dpc8 got %h want %h", D_PC8, 32'h300C); end
  endtask

  task automatic test_branch();
    tick();
    checks++; if (D_Instr !== 32'h1000FFFF) begin errors++; $display("[TB] FAIL br_setup_dinstr got %h want %h", D_Instr, 32'h1000FFFF); end
    checks++; if (D_PC !== 32'h3008) begin errors++; $display("[TB] FAIL br_setup_dpc got %h want %h", D_PC, 32'h3008); end
    NpcSel = 2'b01;
    tick();
    NpcSel = 2'b00;
    checks++; if (F_PC !== 32'h3008) begin errors++; $display("[TB] FAIL br_fpc got %h want %h", F_PC, 32'h3008); end
    checks++; if (D_Instr !== 32'h24030003) begin errors++; $display("[TB] FAIL br_slot_dinstr got %h want %h", D_Instr, 32'h24030003); end
    checks++; if (D_PC !== 32'h300C) begin errors++; $display("[TB] FAIL br_slot_dpc got %h want %h", D_PC, 32'h300C); end
    checks++; if (D_PC8 !== 32'h3014) begin errors++; $display("[TB] FAIL br_slot_dpc8 got %h want %h", D_PC8, 32'h3014); end
  endtask

  task automatic test_jal();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    checks++; if (D_Instr !== 32'h0C000C10) begin errors++; $display("[TB] FAIL jal_setup_dinstr got %h want %h", D_Instr, 32'h0C000C10); end
    checks++; if (D_PC8 !== 32'h3018) begin errors++; $display("[TB] FAIL jal_link got %h want %h", D_PC8, 32'h3018); end
    checks++; if (F_PC !== 32'h3014) begin errors++; $display("[TB] FAIL jal_setup_fpc got %h want %h", F_PC, 32'h3014); end
    NpcSel = 2'b10;
    tick();
    NpcSel = 2'b00;
    checks++; if (F_PC !== 32'h3040) begin errors++; $display("[TB] FAIL jal_fpc got %h want %h", F_PC, 32'h3040); end
    checks++; if (D_Instr !== 32'h24050005) begin errors++; $display("[TB] FAIL jal_slot_dinstr got %h want %h", D_Instr, 32'h24050005); end
    checks++; if (D_PC !== 32'h3014) begin errors++; $display("[TB] FAIL jal_slot_dpc got %h want %h", D_PC, 32'h3014); end
  endtask

  task automatic test_stall();
    Stall = 1'b1; NpcSel = 2'b11; JrTarget = 32'h3100;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (F_PC !== 32'h3040) begin errors++; $display("[TB] FAIL stall%0d_fpc got %h want %h", i, F_PC, 32'h3040); end
      checks++; if (D_Instr !== 32'h24050005) begin errors++; $display("[TB] FAIL stall%0d_dinstr got %h want %h", i, D_Instr, 32'h24050005); end
      checks++; if (D_PC !== 32'h3014) begin errors++; $display("[TB] FAIL stall%0d_dpc got %h want %h", i, D_PC, 32'h3014); end
    end
    Stall = 1'b0;
    tick();
    checks++; if (F_PC !== 32'h3100) begin errors++; $display("[TB] FAIL jr_fpc got %h want %h", F_PC, 32'h3100); end
    checks++; if (D_Instr !== 32'h24100010) begin errors++; $display("[TB] FAIL jr_dinstr got %h want %h", D_Instr, 32'h24100010); end
    checks++; if (D_PC8 !== 32'h3048) begin errors++; $display("[TB] FAIL jr_dpc8 got %h want %h", D_PC8, 32'h3048); end
  endtask

  task automatic test_flush();
    NpcSel = 2'b11; JrTarget = 32'h3020;
    tick();
    checks++; if (F_PC !== 32'h3020) begin errors++; $display("[TB] FAIL fl_setup_fpc got %h want %h", F_PC, 32'h3020); end
    checks++; if (D_Instr !== 32'h24400040) begin errors++; $display("[TB] FAIL fl_setup_dinstr got %h want %h", D_Instr, 32'h24400040); end
    NpcSel = 2'b00; Stall = 1'b1; Flush = 1'b1;
    tick();
    checks++; if (D_Instr !== 32'h24400040) begin errors++; $display("[TB] FAIL stallflush_dinstr got %h want %h", D_Instr, 32'h24400040); end
    checks++; if (F_PC !== 32'h3020) begin errors++; $display("[TB] FAIL stallflush_fpc got %h want %h", F_PC, 32'h3020); end
    Stall = 1'b0;
    tick();
    Flush = 1'b0;
    checks++; if (D_Instr !== 32'h0) begin errors++; $display("[TB] FAIL flush_dinstr got %h want %h", D_Instr, 32'h0); end
    checks++; if (D_PC !== 32'h3020) begin errors++; $display("[TB] FAIL flush_dpc got %h want %h", D_PC, 32'h3020); end
    checks++; if (D_PC8 !== 32'h3028) begin errors++; $display("[TB] FAIL flush_dpc8 got %h want %h", D_PC8, 32'h3028); end
    checks++; if (F_PC !== 32'h3024) begin errors++; $display("[TB] FAIL flush_fpc got %h want %h", F_PC, 32'h3024); end
  endtask

  task automatic test_addr_err();
    NpcSel = 2'b11; JrTarget = 32'h0000_4002;
    tick();
    checks++; if (AddrErr !== 1'b1) begin errors++; $display("[TB] FAIL ae_4002 got %b want 1", AddrErr); end
    checks++; if (ImAddr !== 10'h000) begin errors++; $display("[TB] FAIL ae_4002_imaddr got %h want %h", ImAddr, 10'h000); end
    JrTarget = 32'h0000_3FFC;
    tick();
    checks++; if (AddrErr !== 1'b0) begin errors++; $display("[TB] FAIL ae_3ffc got %b want 0", AddrErr); end
    checks++; if (ImAddr !== 10'h3FF) begin errors++; $display("[TB] FAIL ae_3ffc_imaddr got %h want %h", ImAddr, 10'h3FF); end
    JrTarget = 32'h0000_4000;
    tick();
    checks++; if (AddrErr !== 1'b1) begin errors++; $display("[TB] FAIL ae_4000 got %b want 1", AddrErr); end
    JrTarget = 32'h0000_2FFC;
    tick();
    checks++; if (AddrErr !== 1'b1) begin errors++; $display("[TB] FAIL ae_2ffc got %b want 1", AddrErr); end
    JrTarget = 32'hFFFF_FFFC;
    tick();
    NpcSel = 2'b00;
    tick();
    checks++; if (F_PC !== 32'h0) begin errors++; $display("[TB] FAIL wrap_fpc got %h want %h", F_PC, 32'h0); end
    checks++; if (AddrErr !== 1'b1) begin errors++; $display("[TB] FAIL wrap_addrerr got %b want 1", AddrErr); end
  endtask

  task automatic test_reset_priority();
    NpcSel = 2'b11; JrTarget = 32'h0000_4002;
    tick();
    Reset = 1'b1; Stall = 1'b1; Flush = 1'b1;
    tick();
    Reset = 1'b0; Stall = 1'b0; Flush = 1'b0; NpcSel = 2'b00;
    checks++; if (F_PC !== 32'h3000) begin errors++; $display("[TB] FAIL rstpri_fpc got %h want %h", F_PC, 32'h3000); end
    checks++; if (AddrErr !== 1'b0) begin errors++; $display("[TB] FAIL rstpri_addrerr got %b want 0", AddrErr); end
    checks++; if (D_Instr !== 32'h0) begin errors++; $display("[TB] FAIL rstpri_dinstr got %h want %h", D_Instr, 32'h0); end
    checks++; if (D_PC8 !== 32'h3008) begin errors++; $display("[TB] FAIL rstpri_dpc8 got %h want %h", D_PC8, 32'h3008); end
    tick();
    checks++; if (F_PC !== 32'h3004) begin errors++; $display("[TB] FAIL postrst_fpc got %h want %h", F_PC, 32'h3004); end
    checks++; if (D_Instr !== 32'h24010001) begin errors++; $display("[TB] FAIL postrst_dinstr got %h want %h", D_Instr, 32'h24010001); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]     = 32'h24010001;
    mem[1]     = 32'h24020002;
    mem[2]     = 32'h1000FFFF;
    mem[3]     = 32'h24030003;
    mem[4]     = 32'h0C000C10;
    mem[5]     = 32'h24050005;
    mem[10'h8] = 32'h24080008;
    mem[10'h10] = 32'h24100010;
    mem[10'h40] = 32'h24400040;
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; NpcSel = 2'b00; JrTarget = 32'h0;

    test_reset();
    test_sequential();
    test_branch();
    test_jal();
    test_stall();
    test_flush();
    test_addr_err();
    test_reset_priority();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
